uart_mem_responder: RTL and testbench
=====================================

Name: uart_mem_responder

Overview:
- Host-side responder for the bitty UART fetch/load/store link. It sits behind a uart_module instance on the opposite end of the serial line from the CPU-side fetch and bitty units.
- Decodes byte-framed requests and serves them from internal memories:
  - 256x16 instruction memory (preloaded through a program port).
  - 256x16 data memory.
- Returns 16-bit words as two UART bytes, high byte first.

Parameters:
- TIMEOUT_CYCLES, 100000, max clk cycles between request bytes before the frame is aborted.
- ACK_BYTE, 8'h06, byte returned after a completed store.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-low reset
- rx_done  input  1  one-cycle pulse: rx_data holds a new received byte
- rx_data  input  8  received byte from uart_module
- tx_done  input  1  one-cycle pulse: previous tx byte fully shifted out
- tx_en  output  1  one-cycle pulse requesting transmission of tx_data
- tx_data  output  8  byte to transmit; held stable from tx_en until tx_done
- prog_we  input  1  instruction-memory write strobe
- prog_addr  input  8  instruction-memory write address
- prog_data  input  16  instruction-memory write data
- busy  output  1  high whenever state != IDLE
- err_count  output  8  saturating protocol-error counter

Behaviour:
- Reset is synchronous and active-low on clk.
  - Clears: state=IDLE, tx_en=0, tx_data=0, busy=0, err_count=0, timeout counter=0.
  - Memories are not cleared.
  - Reset mid-frame aborts immediately; no further bytes are transmitted.
- Frame formats (bytes in arrival order):
  - 8'h01 ADDR = instruction fetch; reply IMEM[ADDR][15:8], then IMEM[ADDR][7:0].
  - 8'h02 ADDR = data load; reply DMEM[ADDR][15:8], then DMEM[ADDR][7:0].
  - 8'h03 ADDR HI LO = data store; DMEM[ADDR] <= {HI,LO}; reply ACK_BYTE.
  - Any other first byte: discarded, err_count+1, stay IDLE.
- States: IDLE, GET_ADDR, GET_HI, GET_LO, READ, SEND_HI, WAIT_HI, SEND_LO, WAIT_LO, WRITE, SEND_ACK, WAIT_ACK.
  - IDLE: on rx_done, latch opcode. Valid opcode -> GET_ADDR.
  - GET_ADDR: on rx_done, latch address. Opcode 01/02 -> READ; opcode 03 -> GET_HI.
  - GET_HI -> GET_LO -> WRITE, each advancing on rx_done.
  - READ: one cycle, registered memory read into a 16-bit word register -> SEND_HI.
  - SEND_HI: tx_data=word[15:8], tx_en=1 for exactly one cycle -> WAIT_HI.
  - WAIT_HI: on tx_done -> SEND_LO.
  - SEND_LO: tx_data=word[7:0], tx_en=1 for one cycle -> WAIT_LO.
  - WAIT_LO: on tx_done -> IDLE.
  - WRITE: one cycle DMEM write -> SEND_ACK.
  - SEND_ACK: tx_en pulse with ACK_BYTE -> WAIT_ACK.
  - WAIT_ACK: on tx_done -> IDLE.
- Latency: first tx_en asserts 2 cycles after the rx_done of the last request byte (READ, then SEND_*).
- tx_en is never asserted while waiting for a tx_done. tx_done arriving in any non-WAIT state is ignored.
- Timeout:
  - Counter clears on each rx_done and on entry to any GET_* state.
  - In GET_* states, when the counter reaches TIMEOUT_CYCLES-1 with no rx_done: -> IDLE, err_count+1, partial frame discarded, no DMEM write.
- Overrun: rx_done in READ/SEND_*/WAIT_*/WRITE drops the byte and increments err_count; the state machine continues unaffected.
- err_count saturates at 8'hFF. Simultaneous error sources in one cycle count once.
- prog_we writes IMEM on any cycle, including while busy. If a same-address write coincides with the READ cycle, the read returns the old word (read-before-write).
- Address is 8 bits; all 256 locations are valid; there is no wrap logic.

Test Plan:
- prog_we loads IMEM[8'h10]=16'hA5C3; send 01,10 -> tx bytes A5 then C3; second tx_en only after the first tx_done; busy low after the final tx_done.
- Send 03,22,BE,EF -> tx 06; then 02,22 -> tx BE, EF; err_count stays 0.
- Send 7F, then 01,10 -> err_count=1; reply A5, C3 (the stray byte is not consumed as an address).
- Send 03,22 then idle TIMEOUT_CYCLES (TIMEOUT_CYCLES=50 in bench) -> IDLE, err_count=1, DMEM[22] unchanged, no tx_en.
- Extra rx_done during WAIT_HI of a fetch -> err_count+1; both reply bytes still sent correctly.
- Assert reset in WAIT_HI -> tx_en never pulses again, busy=0, err_count=0; IMEM contents preserved on the next fetch.

Source files
------------

// File: rtl/uart_mem_responder_if.sv
// Byte-level link between the responder and its uart_module: received-byte
// strobe in, transmit request out, transmit-complete strobe back in.
// A byte is received when rx_done pulses for one cycle; a byte is sent by a
// one-cycle tx_en pulse with tx_data held until the matching tx_done pulse.
interface uart_mem_responder_if;
  logic       rx_done;
  logic [7:0] rx_data;
  logic       tx_done;
  logic       tx_en;
  logic [7:0] tx_data;

  modport slave (
    input  rx_done, rx_data, tx_done,
    output tx_en, tx_data
  );

  modport master (
    output rx_done, rx_data, tx_done,
    input  tx_en, tx_data
  );
endinterface

// File: rtl/uart_mem_responder.sv
// Host-side responder: decodes fetch/load/store byte frames from the UART and
// serves them from a 256x16 instruction memory and a 256x16 data memory.
module uart_mem_responder #(
  parameter int         TIMEOUT_CYCLES = 100000,
  parameter logic [7:0] ACK_BYTE       = 8'h06
) (
  input  logic                  clk,
  input  logic                  reset,
  uart_mem_responder_if.slave   link,
  input  logic                  prog_we,
  input  logic [7:0]            prog_addr,
  input  logic [15:0]           prog_data,
  output logic                  busy,
  output logic [7:0]            err_count,
  output logic [3:0]            state_dbg
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] OP_FETCH = 8'h01;
  localparam logic [7:0] OP_LOAD  = 8'h02;
  localparam logic [7:0] OP_STORE = 8'h03;

  typedef enum logic [3:0] {
    IDLE, GET_ADDR, GET_HI, GET_LO, READ, SEND_HI, WAIT_HI,
    SEND_LO, WAIT_LO, WRITE, SEND_ACK, WAIT_ACK
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [7:0]    opcode;
  logic [7:0]    addr;
  logic [7:0]    hi;
  logic [7:0]    lo;
  logic [15:0]   word;
  logic [15:0]   rd_word;
  logic          err_inc;
  logic          op_valid;

  logic [15:0] imem [256];
  logic [15:0] dmem [256];

  assign busy      = (state != IDLE);
  assign state_dbg = state;
  assign op_valid  = (link.rx_data == OP_FETCH) || (link.rx_data == OP_LOAD) ||
                     (link.rx_data == OP_STORE);

  // Error sources are tied to disjoint states, so at most one fires per cycle.
  always_comb begin
    err_inc = 1'b0;
    case (state)
      IDLE:                     err_inc = link.rx_done && !op_valid;
      GET_ADDR, GET_HI, GET_LO: err_inc = !link.rx_done && (cnt == CNT_LAST);
      default:                  err_inc = link.rx_done;
    endcase
  end

  always_comb begin
    rd_word = (opcode == OP_FETCH) ? imem[addr] : dmem[addr];
  end

  always_ff @(posedge clk) begin
    if (prog_we) imem[prog_addr] <= prog_data;
  end

  always_ff @(posedge clk) begin
    if (reset && state == WRITE) dmem[addr] <= {hi, lo};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      link.tx_en   <= 1'b0;
      link.tx_data <= 8'h00;
      err_count    <= 8'h00;
      cnt          <= '0;
      opcode       <= 8'h00;
      addr         <= 8'h00;
      hi           <= 8'h00;
      lo           <= 8'h00;
      word         <= 16'h0000;
    end else begin
      link.tx_en <= 1'b0;
      if (err_inc && err_count != 8'hFF) err_count <= err_count + 8'd1;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (link.rx_done) begin
            opcode <= link.rx_data;
            if (op_valid) state <= GET_ADDR;
          end
        end
        GET_ADDR, GET_HI, GET_LO: begin
          if (link.rx_done) begin
            cnt <= '0;
            case (state)
              GET_ADDR: begin
                addr  <= link.rx_data;
                state <= (opcode == OP_STORE) ? GET_HI : READ;
              end
              GET_HI: begin
                hi    <= link.rx_data;
                state <= GET_LO;
              end
              default: begin
                lo    <= link.rx_data;
                state <= WRITE;
              end
            endcase
          end else if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        // tx_en is raised on entry to each SEND_* state so it is high only there.
        READ: begin
          word         <= rd_word;
          link.tx_data <= rd_word[15:8];
          link.tx_en   <= 1'b1;
          state        <= SEND_HI;
        end
        SEND_HI: state <= WAIT_HI;
        WAIT_HI: begin
          if (link.tx_done) begin
            link.tx_data <= word[7:0];
            link.tx_en   <= 1'b1;
            state        <= SEND_LO;
          end
        end
        SEND_LO: state <= WAIT_LO;
        WAIT_LO: if (link.tx_done) state <= IDLE;
        WRITE: begin
          link.tx_data <= ACK_BYTE;
          link.tx_en   <= 1'b1;
          state        <= SEND_ACK;
        end
        SEND_ACK: state <= WAIT_ACK;
        WAIT_ACK: if (link.tx_done) state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mem_responder.sv
// Directed bench for uart_mem_responder: frame-level memory model feeds an
// expected-byte queue that a per-cycle compare process checks against tx.
module tb_uart_mem_responder;

  localparam int TIMEOUT_CYCLES = 50;

  logic        clk;
  logic        reset;
  logic        prog_we;
  logic [7:0]  prog_addr;
  logic [15:0] prog_data;
  logic        busy;
  logic [7:0]  err_count;
  logic [3:0]  state_dbg;

  uart_mem_responder_if bus ();

  uart_mem_responder #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .ACK_BYTE(8'h06)) dut (
    .clk       (clk),
    .reset     (reset),
    .link      (bus.slave),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .busy      (busy),
    .err_count (err_count),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model state
  logic [15:0] imem_m [256];
  logic [15:0] dmem_m [256];
  logic [8:0]  exp_q [$];   // {first byte of reply, byte}
  logic [7:0]  got_q [$];
  int          err_exp;
  int          n_checks;
  int          n_fail;
  logic        outstanding;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    bus.rx_done = 1'b1;
    bus.rx_data = b;
    @(posedge clk); #1;
    bus.rx_done = 1'b0;
  endtask

  task automatic prog_write(input logic [7:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    @(posedge clk); #1;
    prog_we = 1'b0;
    imem_m[a] = d;
  endtask

  task automatic send_req(input logic [7:0] op, input logic [7:0] a,
                          input logic [7:0] h, input logic [7:0] l);
    case (op)
      8'h01: begin exp_q.push_back({1'b1, imem_m[a][15:8]}); exp_q.push_back({1'b0, imem_m[a][7:0]}); end
      8'h02: begin exp_q.push_back({1'b1, dmem_m[a][15:8]}); exp_q.push_back({1'b0, dmem_m[a][7:0]}); end
      default: begin dmem_m[a] = {h, l}; exp_q.push_back({1'b1, 8'h06}); end
    endcase
    send_byte(op);
    send_byte(a);
    if (op == 8'h03) begin
      send_byte(h);
      send_byte(l);
    end
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && !busy) break;
    end
    check({name, "_pending"}, exp_q.size(), 0);
    check({name, "_busy"}, busy, 1'b0);
    check({name, "_err"}, err_count, err_exp[7:0]);
  endtask

  // remote uart: acknowledges every transmit a few cycles later
  initial begin
    bus.tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.tx_en) begin
        repeat (3) @(posedge clk);
        #1 bus.tx_done = 1'b1;
        @(posedge clk);
        #1 bus.tx_done = 1'b0;
      end
    end
  end

  // scoreboard: every transmitted byte must be expected, in order, one at a time
  initial begin
    int ncyc;
    int last_rx;
    logic [8:0] e;
    ncyc = 0;
    last_rx = 0;
    outstanding = 1'b0;
    forever begin
      @(negedge clk);
      ncyc++;
      if (!reset) outstanding = 1'b0;
      if (bus.rx_done) last_rx = ncyc;
      if (bus.tx_done) outstanding = 1'b0;
      if (bus.tx_en) begin
        check("tx_busy", busy, 1'b1);
        check("tx_while_waiting", outstanding, 1'b0);
        if (exp_q.size() == 0) begin
          check("tx_spurious", bus.tx_en, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("tx_byte", bus.tx_data, e[7:0]);
          if (e[8]) check("tx_latency", ncyc - last_rx, 2);
        end
        got_q.push_back(bus.tx_data);
        outstanding = 1'b1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] lit [23];
    lit = '{8'hA5, 8'hC3, 8'h06, 8'hBE, 8'hEF, 8'hA5, 8'hC3, 8'hBE, 8'hEF,
            8'hA5, 8'hC3, 8'h06, 8'h5A, 8'h69, 8'h12, 8'h34, 8'hA5, 8'hA5,
            8'hC3, 8'hA5, 8'hC3, 8'h0F, 8'h0F};
    n_checks = 0;
    n_fail = 0;
    err_exp = 0;
    reset = 1'b0;
    prog_we = 1'b0; prog_addr = 8'h00; prog_data = 16'h0000;
    bus.rx_done = 1'b0; bus.rx_data = 8'h00;
    for (int i = 0; i < 256; i++) begin imem_m[i] = 'x; dmem_m[i] = 'x; end

    prog_write(8'h10, 16'hA5C3);
    prog_write(8'hFF, 16'h1234);
    check("rst_tx_en", bus.tx_en, 1'b0);
    check("rst_tx_data", bus.tx_data, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err_count, 8'h00);
    @(posedge clk); #1 reset = 1'b1;

    // fetch
    send_req(8'h01, 8'h10, 8'h00, 8'h00);
    wait_idle("fetch");

    // store then load back
    send_req(8'h03, 8'h22, 8'hBE, 8'hEF);
    wait_idle("store");
    send_req(8'h02, 8'h22, 8'h00, 8'h00);
    wait_idle("load");

    // bad opcode is dropped and not taken as an address
    send_byte(8'h7F);
    err_exp++;
    send_req(8'h01, 8'h10, 8'h00, 8'h00);
    wait_idle("bad_op");

    // partial store times out after TIMEOUT_CYCLES idle cycles
    send_byte(8'h03);
    send_byte(8'h22);
    repeat (TIMEOUT_CYCLES - 1) @(posedge clk);
    #1 check("timeout_not_yet", busy, 1'b1);
    @(posedge clk); #1;
    check("timeout_idle", busy, 1'b0);
    err_exp++;
    check("timeout_err", err_count, err_exp[7:0]);
    send_req(8'h02, 8'h22, 8'h00, 8'h00);
    wait_idle("after_timeout");

    // overrun byte during WAIT_HI
    send_req(8'h01, 8'h10, 8'h00, 8'h00);
    repeat (2) @(posedge clk);
    send_byte(8'h55);
    err_exp++;
    wait_idle("overrun");

    // top address
    send_req(8'h03, 8'hFF, 8'h5A, 8'h69);
    wait_idle("store_ff");
    send_req(8'h02, 8'hFF, 8'h00, 8'h00);
    wait_idle("load_ff");
    send_req(8'h01, 8'hFF, 8'h00, 8'h00);
    wait_idle("fetch_ff");

    // reset while waiting for the first tx_done
    send_req(8'h01, 8'h10, 8'h00, 8'h00);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    exp_q.delete();
    err_exp = 0;
    @(posedge clk); #1 reset = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_err", err_count, 8'h00);
    check("mid_rst_tx_data", bus.tx_data, 8'h00);
    send_req(8'h01, 8'h10, 8'h00, 8'h00);
    wait_idle("after_rst");

    // program write in the READ cycle: reply carries the old word
    send_req(8'h01, 8'h10, 8'h00, 8'h00);
    prog_we = 1'b1; prog_addr = 8'h10; prog_data = 16'h0F0F;
    @(posedge clk); #1 prog_we = 1'b0;
    imem_m[8'h10] = 16'h0F0F;
    wait_idle("rbw_old");
    send_req(8'h01, 8'h10, 8'h00, 8'h00);
    wait_idle("rbw_new");

    // pin the model with the hand-computed byte stream
    check("tx_count", got_q.size(), 23);
    for (int i = 0; i < 23; i++) begin
      if (i < got_q.size()) check($sformatf("tx_lit_%0d", i), got_q[i], lit[i]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
